// File: rtl/stream_downsize.sv
// Wide-to-narrow stream serialiser: one buffered wide beat is emitted one kept lane per transfer.
// Optional macro STREAM_DOWNSIZE_BACK2BACK_EN lets the buffer reload while its final lane is sent.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int LW = $clog2(T_DATA_RATIO);
    localparam logic [T_DATA_RATIO-1:0] LANE0 = {{(T_DATA_RATIO-1){1'b0}}, 1'b1};

    // Implicit state, exposed as a named signal so checkers can bind to it.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] rem_q;
    logic                    last_q;
    logic                    full_q;
    logic [0:0]              state;

    logic [LW-1:0]           lane;
    logic [T_DATA_RATIO-1:0] lane_mask;
    logic                    one_left;
    logic                    accept;
    logic                    send;

    assign state = full_q ? ST_DRAIN : ST_EMPTY;

    // Scan downward so the lowest set bit wins.
    always_comb begin
        lane = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (rem_q[i]) lane = i[LW-1:0];
        end
    end

    assign lane_mask = LANE0 << lane;
    assign one_left  = (rem_q != '0) && ((rem_q & (rem_q - LANE0)) == '0);

    assign m_valid_o = full_q;
    assign m_data_o  = data_q[lane];
    assign m_last_o  = full_q && last_q && one_left;

`ifdef STREAM_DOWNSIZE_BACK2BACK_EN
    assign s_ready_o = !rst_n && ((state == ST_EMPTY) || (m_ready_i && one_left));
`else
    assign s_ready_o = !rst_n && (state == ST_EMPTY);
`endif

    assign accept = s_valid_i && s_ready_o;
    assign send   = full_q && m_ready_i;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < T_DATA_RATIO; i++) data_q[i] <= '0;
            rem_q  <= '0;
            last_q <= 1'b0;
            full_q <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < T_DATA_RATIO; i++) data_q[i] <= s_data_i[i];
            // An all-zero keep still carries lane 0 so the last flag is never dropped.
            rem_q  <= (s_keep_i == '0) ? LANE0 : s_keep_i;
            last_q <= s_last_i;
            full_q <= 1'b1;
        end else if (send) begin
            rem_q <= rem_q & ~lane_mask;
            if (one_left) full_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
// Directed bench for stream_downsize (width 4, ratio 2); covers both builds of the back-to-back option.
module tb_stream_downsize;

    logic       clk;
    logic       rst_n;
    logic [3:0] s_data [2];
    logic [1:0] s_keep;
    logic       s_last;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] m_data;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;

    int checks = 0;
    int errors = 0;

    stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data),
        .s_keep_i  (s_keep),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks outputs at the falling edge, then returns 1 time unit after the next rising edge.
    task automatic cyc(input string tag, input logic ev, input logic [3:0] ed,
                       input logic el, input logic esr);
        @(negedge clk);
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(ev));
        if (ev) chk({tag, ".m_data"}, 32'(m_data), 32'(ed));
        chk({tag, ".m_last"}, 32'(m_last), 32'(el));
        chk({tag, ".s_ready"}, 32'(s_ready), 32'(esr));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] d0, input logic [3:0] d1,
                         input logic [1:0] keep, input logic last);
        s_data[0] = d0;
        s_data[1] = d1;
        s_keep    = keep;
        s_last    = last;
        s_valid   = 1'b1;
    endtask

    logic       ev [10];
    logic [3:0] ed [10];
    logic       el [10];
    logic       esr[10];
    int         n_b2b;
    int         beat;

    initial begin
        rst_n   = 1'b1;
        s_data[0] = '0;
        s_data[1] = '0;
        s_keep  = '0;
        s_last  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst.m_valid", 32'(m_valid), 32'd0);
        chk("rst.m_last",  32'(m_last),  32'd0);
        chk("rst.m_data",  32'(m_data),  32'd0);
        chk("rst.s_ready", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // Full keep, no last
        drive(4'h1, 4'hA, 2'b11, 1'b0);
        cyc("t1.load", 0, 4'h0, 0, 1);
        s_valid = 1'b0;
        cyc("t1.lane0", 1, 4'h1, 0, 0);
        cyc("t1.lane1", 1, 4'hA, 0, 0);
        cyc("t1.idle",  0, 4'h0, 0, 1);

        // Single lane with last
        drive(4'h6, 4'h0, 2'b01, 1'b1);
        cyc("t2.load", 0, 4'h0, 0, 1);
        s_valid = 1'b0;
        cyc("t2.lane0", 1, 4'h6, 1, 0);
        cyc("t2.idle",  0, 4'h0, 0, 1);

        // Only the upper lane kept
        drive(4'h5, 4'hA, 2'b10, 1'b0);
        cyc("t3.load", 0, 4'h0, 0, 1);
        s_valid = 1'b0;
        cyc("t3.lane1", 1, 4'hA, 0, 0);
        cyc("t3.idle",  0, 4'h0, 0, 1);

        // Empty keep with last still sends lane 0
        drive(4'h9, 4'h7, 2'b00, 1'b1);
        cyc("t4.load", 0, 4'h0, 0, 1);
        s_valid = 1'b0;
        cyc("t4.lane0", 1, 4'h9, 1, 0);
        cyc("t4.idle",  0, 4'h0, 0, 1);

        // Backpressure for 3 cycles
        drive(4'h1, 4'hA, 2'b11, 1'b0);
        m_ready = 1'b0;
        cyc("t5.load", 0, 4'h0, 0, 1);
        s_valid = 1'b0;
        cyc("t5.hold0", 1, 4'h1, 0, 0);
        cyc("t5.hold1", 1, 4'h1, 0, 0);
        cyc("t5.hold2", 1, 4'h1, 0, 0);
        m_ready = 1'b1;
        cyc("t5.lane0", 1, 4'h1, 0, 0);
        cyc("t5.lane1", 1, 4'hA, 0, 0);
        cyc("t5.idle",  0, 4'h0, 0, 1);

        // Three back-to-back beats with s_valid held high
`ifdef STREAM_DOWNSIZE_BACK2BACK_EN
        n_b2b = 8;
        ev  = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        ed  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h0, 4'h0, 4'h0};
        el  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        esr = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 0};
`else
        n_b2b = 10;
        ev  = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
        ed  = '{4'h0, 4'h1, 4'h2, 4'h0, 4'h3, 4'h4, 4'h0, 4'h5, 4'h6, 4'h0};
        el  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        esr = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
`endif
        beat = 0;
        drive(4'h1, 4'h2, 2'b11, 1'b0);
        for (int c = 0; c < n_b2b; c++) begin
            @(negedge clk);
            chk($sformatf("t6.c%0d.m_valid", c), 32'(m_valid), 32'(ev[c]));
            if (ev[c]) chk($sformatf("t6.c%0d.m_data", c), 32'(m_data), 32'(ed[c]));
            chk($sformatf("t6.c%0d.m_last", c), 32'(m_last), 32'(el[c]));
            chk($sformatf("t6.c%0d.s_ready", c), 32'(s_ready), 32'(esr[c]));
            if (s_valid && s_ready) beat++;
            @(posedge clk);
            #1;
            if (beat == 1 && s_data[0] == 4'h1) drive(4'h3, 4'h4, 2'b11, 1'b0);
            else if (beat == 2 && s_data[0] == 4'h3) drive(4'h5, 4'h6, 2'b11, 1'b1);
            else if (beat == 3) s_valid = 1'b0;
        end
        chk("t6.beats", 32'(beat), 32'd3);

        // Reset asserted mid-beat
        drive(4'h1, 4'hA, 2'b11, 1'b0);
        cyc("t7.load", 0, 4'h0, 0, 1);
        s_valid = 1'b0;
        cyc("t7.lane0", 1, 4'h1, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("t7.rst.m_valid", 32'(m_valid), 32'd0);
        chk("t7.rst.s_ready", 32'(s_ready), 32'd0);
        chk("t7.rst.m_data",  32'(m_data),  32'd0);
        cyc("t7.in_rst", 0, 4'h0, 0, 0);
        rst_n = 1'b0;
        drive(4'h3, 4'h2, 2'b11, 1'b0);
        cyc("t7.reload", 0, 4'h0, 0, 1);
        s_valid = 1'b0;
        cyc("t7.lane0b", 1, 4'h3, 0, 0);
        cyc("t7.lane1b", 1, 4'h2, 0, 0);
        cyc("t7.idle",   0, 4'h0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
